// File: rtl/adc_scan_controller.sv
`timescale 1ns/1ps
// adc_scan_controller
// Serial master for the ADC128S022 line-follower sensor ADC. Round-robins
// three channels (CH_A, CH_B, CH_C), drives CS/SCK/DIN, shifts in DOUT and
// keeps the latest 12-bit result of each channel. scan_done pulses for one
// cycle whenever the CH_C result is written (one full A/B/C scan).
// Optional feature: define ADC_AVG_EN to make each output the two-sample
// average of the current and previous conversion of that channel.
module adc_scan_controller #(
  parameter logic [2:0] CH_A = 3'd5,
  parameter logic [2:0] CH_B = 3'd6,
  parameter logic [2:0] CH_C = 3'd7
) (
  input  logic        clk_3125KHz,
  input  logic        rst_n,
  input  logic        adc_dout,
  output logic        adc_cs_n,
  output logic        adc_sck,
  output logic        adc_din,
  output logic [11:0] d_out_a,
  output logic [11:0] d_out_b,
  output logic [11:0] d_out_c,
  output logic        scan_done
);

  localparam logic [5:0] P_LAST = 6'd33;

  typedef enum logic [1:0] {
    SEQ_A = 2'd0,
    SEQ_B = 2'd1,
    SEQ_C = 2'd2
  } seq_t;

  logic [5:0]  p;
  logic [5:0]  p_next;
  logic        frame_end;
  logic        sample_bit;
  logic        cs_n_next;
  logic        sck_next;
  logic        din_next;
  seq_t        seq;
  seq_t        seq_next;
  seq_t        tag;
  seq_t        tag_next;
  logic        first_frame;
  logic        first_frame_next;
  logic [2:0]  seq_addr;
  logic [10:0] shift;
  logic [11:0] result;
  logic [11:0] upd_value;
  logic        write_en;

  // Phase bookkeeping: next phase, last-phase flag and DOUT sample slots
  always_comb begin
    p_next     = (p == P_LAST) ? 6'd0 : p + 6'd1;
    frame_end  = (p == P_LAST);
    sample_bit = (p >= 6'd3) && p[0];
  end

  // Phase counter, 0..33 then wrap; reset abandons any partial frame
  always_ff @(posedge clk_3125KHz or negedge rst_n) begin
    if (!rst_n) begin
      p <= 6'd0;
    end else begin
      p <= p_next;
    end
  end

  // ADC address of the channel whose address goes out in this frame
  always_comb begin
    case (seq)
      SEQ_A:   seq_addr = CH_A;
      SEQ_B:   seq_addr = CH_B;
      default: seq_addr = CH_C;
    endcase
  end

  // Pin levels for the coming phase; DIN only moves on entry to an SCK-low half
  always_comb begin
    cs_n_next = (p_next < 6'd2);
    sck_next  = (p_next < 6'd2) || p_next[0];
    din_next  = adc_din;
    if (p_next < 6'd2) begin
      din_next = 1'b0;
    end else if (!p_next[0]) begin
      case (p_next)
        6'd6:    din_next = seq_addr[2];
        6'd8:    din_next = seq_addr[1];
        6'd10:   din_next = seq_addr[0];
        default: din_next = 1'b0;
      endcase
    end
  end

  // Registered serial pins so CS/SCK/DIN are glitch-free at the ADC
  always_ff @(posedge clk_3125KHz or negedge rst_n) begin
    if (!rst_n) begin
      adc_cs_n <= 1'b1;
      adc_sck  <= 1'b1;
      adc_din  <= 1'b0;
    end else begin
      adc_cs_n <= cs_n_next;
      adc_sck  <= sck_next;
      adc_din  <= din_next;
    end
  end

  // DOUT shift register, MSB first; the four leading bits fall off the top
  always_ff @(posedge clk_3125KHz or negedge rst_n) begin
    if (!rst_n) begin
      shift <= 11'd0;
    end else if (sample_bit) begin
      shift <= {shift[9:0], adc_dout};
    end
  end

  // The last data bit is taken straight from the pin on the frame-end edge
  assign result   = {shift, adc_dout};
  assign write_en = frame_end && !first_frame;

  // Scan sequencer: next channel to address and tag for the data now arriving
  always_comb begin
    seq_next         = seq;
    tag_next         = tag;
    first_frame_next = first_frame;
    if (frame_end) begin
      tag_next         = seq;
      first_frame_next = 1'b0;
      case (seq)
        SEQ_A:   seq_next = SEQ_B;
        SEQ_B:   seq_next = SEQ_C;
        default: seq_next = SEQ_A;
      endcase
    end
  end

  // Sequencer state; the power-up frame converts channel 0 and is dropped
  always_ff @(posedge clk_3125KHz or negedge rst_n) begin
    if (!rst_n) begin
      seq         <= SEQ_A;
      tag         <= SEQ_A;
      first_frame <= 1'b1;
    end else begin
      seq         <= seq_next;
      tag         <= tag_next;
      first_frame <= first_frame_next;
    end
  end

`ifdef ADC_AVG_EN
  logic [11:0] prev_a;
  logic [11:0] prev_b;
  logic [11:0] prev_c;
  logic        seeded_a;
  logic        seeded_b;
  logic        seeded_c;
  logic [11:0] tag_prev;
  logic        tag_seeded;
  logic [12:0] avg_sum;

  // Average with the previous raw sample of the tagged channel once seeded
  always_comb begin
    tag_prev   = 12'd0;
    tag_seeded = 1'b0;
    case (tag)
      SEQ_A: begin
        tag_prev   = prev_a;
        tag_seeded = seeded_a;
      end
      SEQ_B: begin
        tag_prev   = prev_b;
        tag_seeded = seeded_b;
      end
      default: begin
        tag_prev   = prev_c;
        tag_seeded = seeded_c;
      end
    endcase
    avg_sum   = {1'b0, tag_prev} + {1'b0, result};
    upd_value = tag_seeded ? avg_sum[12:1] : result;
  end

  // Remember each channel's last raw sample for the next average
  always_ff @(posedge clk_3125KHz or negedge rst_n) begin
    if (!rst_n) begin
      prev_a   <= 12'd0;
      prev_b   <= 12'd0;
      prev_c   <= 12'd0;
      seeded_a <= 1'b0;
      seeded_b <= 1'b0;
      seeded_c <= 1'b0;
    end else if (write_en) begin
      case (tag)
        SEQ_A: begin
          prev_a   <= result;
          seeded_a <= 1'b1;
        end
        SEQ_B: begin
          prev_b   <= result;
          seeded_b <= 1'b1;
        end
        default: begin
          prev_c   <= result;
          seeded_c <= 1'b1;
        end
      endcase
    end
  end
`else
  assign upd_value = result;
`endif

  // Result registers and the scan-complete strobe
  always_ff @(posedge clk_3125KHz or negedge rst_n) begin
    if (!rst_n) begin
      d_out_a   <= 12'd0;
      d_out_b   <= 12'd0;
      d_out_c   <= 12'd0;
      scan_done <= 1'b0;
    end else begin
      scan_done <= write_en && (tag == SEQ_C);
      if (write_en) begin
        case (tag)
          SEQ_A:   d_out_a <= upd_value;
          SEQ_B:   d_out_b <= upd_value;
          default: d_out_c <= upd_value;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_adc_scan_controller.sv
`timescale 1ns/1ps
// Testbench for adc_scan_controller: behavioural ADC128S022 model plus a
// scoreboard of per-frame expected outputs checked by a frame-end monitor.
module tb_adc_scan_controller;

  logic        clk_3125KHz;
  logic        rst_n;
  logic        adc_dout;
  logic        adc_cs_n;
  logic        adc_sck;
  logic        adc_din;
  logic [11:0] d_out_a;
  logic [11:0] d_out_b;
  logic [11:0] d_out_c;
  logic        scan_done;

  typedef struct {
    logic [11:0] a;
    logic [11:0] b;
    logic [11:0] c;
    logic        sd;
    logic [2:0]  addr;
  } exp_t;

  exp_t        sb_q[$];
  int          checks = 0;
  int          errors = 0;
  logic        junk = 1'b0;

  // ADC model state and per-frame snapshot
  logic [2:0]  model_addr;
  logic [15:0] din_sr;
  logic [15:0] tx_word;
  int          sck_rises;
  int          cs_cycles;
  int          ch5_count;
  int          cs_falls;
  logic [2:0]  fr_addr;
  logic [15:0] fr_din_other;
  int          fr_sck;
  int          fr_cs;

  // Cycle counter, reset epochs and forbidden-value watch
  int          cyc = 0;
  int          rst_epoch = 0;
  logic        saw_555 = 1'b0;

  // Expected-value shadow
  int          frame_no;
  int          exp_ch5_idx;
  logic [11:0] exp_a;
  logic [11:0] exp_b;
  logic [11:0] exp_c;

  adc_scan_controller dut (
    .clk_3125KHz(clk_3125KHz),
    .rst_n      (rst_n),
    .adc_dout   (adc_dout),
    .adc_cs_n   (adc_cs_n),
    .adc_sck    (adc_sck),
    .adc_din    (adc_din),
    .d_out_a    (d_out_a),
    .d_out_b    (d_out_b),
    .d_out_c    (d_out_c),
    .scan_done  (scan_done)
  );

  initial begin
    clk_3125KHz = 1'b0;
    forever #160 clk_3125KHz = ~clk_3125KHz;
  end

  function automatic logic [11:0] model_ch5(input int idx);
`ifdef ADC_AVG_EN
    return (idx == 0) ? 12'h100 : 12'h201;
`else
    return (idx >= 0) ? 12'h123 : 12'h123;
`endif
  endfunction

  function automatic logic [11:0] exp_ch5(input int idx);
`ifdef ADC_AVG_EN
    if (idx == 0) return 12'h100;
    else if (idx == 1) return 12'h180;
    else return 12'h201;
`else
    return (idx >= 0) ? 12'h123 : 12'h123;
`endif
  endfunction

  function automatic logic [11:0] model_value(input logic [2:0] ch, input int n5);
    case (ch)
      3'd5:    return model_ch5(n5);
      3'd6:    return 12'hABC;
      3'd7:    return 12'hFFF;
      3'd0:    return 12'h555;
      default: return 12'h000;
    endcase
  endfunction

  function automatic logic [2:0] addr_of(input int i);
    case (i)
      0:       return 3'd5;
      1:       return 3'd6;
      default: return 3'd7;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic resetShadow();
    frame_no    = 0;
    exp_ch5_idx = 0;
    exp_a       = 12'd0;
    exp_b       = 12'd0;
    exp_c       = 12'd0;
  endtask

  // Push expected frame-end outputs for the next n frames
  task automatic applyStimulus(input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      frame_no++;
      e.addr = addr_of((frame_no - 1) % 3);
      e.sd   = 1'b0;
      if (frame_no >= 2) begin
        case ((frame_no - 2) % 3)
          0: begin
            exp_a = exp_ch5(exp_ch5_idx);
            exp_ch5_idx++;
          end
          1: exp_b = 12'hABC;
          default: begin
            exp_c = 12'hFFF;
            e.sd  = 1'b1;
          end
        endcase
      end
      e.a = exp_a;
      e.b = exp_b;
      e.c = exp_c;
      sb_q.push_back(e);
    end
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < budget) begin
      @(negedge clk_3125KHz);
      n++;
    end
    if (sb_q.size() != 0) begin
      checkOutput("drain_timeout", sb_q.size(), 0);
      sb_q.delete();
    end
    repeat (4) @(negedge clk_3125KHz);
  endtask

  task automatic check_reset_state(input string tagname);
    checkOutput({tagname, "_cs_n"}, adc_cs_n, 1);
    checkOutput({tagname, "_sck"}, adc_sck, 1);
    checkOutput({tagname, "_din"}, adc_din, 0);
    checkOutput({tagname, "_a"}, d_out_a, 0);
    checkOutput({tagname, "_b"}, d_out_b, 0);
    checkOutput({tagname, "_c"}, d_out_c, 0);
    checkOutput({tagname, "_scan_done"}, scan_done, 0);
  endtask

  // Behavioural ADC: DOUT shifts on SCK falling, DIN captured on SCK rising,
  // address sent in one frame selects the conversion of the next frame
  initial begin : adc_model
    logic prev_cs;
    logic prev_sck;
    logic prev_clk;
    prev_cs  = 1'b1;
    prev_sck = 1'b1;
    prev_clk = 1'b0;
    adc_dout = 1'b0;
    forever begin
      @(adc_cs_n or adc_sck or rst_n or clk_3125KHz);
      if (!rst_n) begin
        model_addr = 3'd0;
        sck_rises  = 0;
        din_sr     = 16'd0;
        cs_cycles  = 0;
        ch5_count  = 0;
        cs_falls   = 0;
        adc_dout   = 1'b0;
      end else begin
        if (prev_cs && !adc_cs_n) begin
          tx_word   = {(junk ? 4'hA : 4'h0), model_value(model_addr, ch5_count)};
          if (model_addr == 3'd5) ch5_count++;
          adc_dout  = tx_word[15];
          sck_rises = 0;
          din_sr    = 16'd0;
          cs_cycles = 0;
          cs_falls++;
        end
        if (!adc_cs_n && !prev_sck && adc_sck) begin
          din_sr = {din_sr[14:0], adc_din};
          sck_rises++;
        end
        if (!adc_cs_n && prev_sck && !adc_sck && sck_rises > 0 && sck_rises < 16)
          adc_dout = tx_word[15 - sck_rises];
        if (prev_clk && !clk_3125KHz && !adc_cs_n)
          cs_cycles++;
        if (!prev_cs && adc_cs_n) begin
          fr_addr      = din_sr[13:11];
          fr_din_other = din_sr & 16'hC7FF;
          fr_sck       = sck_rises;
          fr_cs        = cs_cycles;
          model_addr   = din_sr[13:11];
          adc_dout     = 1'b0;
        end
      end
      prev_cs  = adc_cs_n;
      prev_sck = adc_sck;
      prev_clk = clk_3125KHz;
    end
  end

  // Free-running cycle count, reset epochs and forbidden-value watch
  initial begin
    forever begin
      @(negedge clk_3125KHz);
      cyc++;
      if (!rst_n) rst_epoch++;
      if (rst_n && (d_out_a == 12'h555 || d_out_b == 12'h555 || d_out_c == 12'h555))
        saw_555 = 1'b1;
    end
  end

  // Monitor: every completed frame pops one expectation and compares
  initial begin : monitor
    exp_t e;
    int   last_sd_cyc;
    int   last_sd_epoch;
    logic sd_valid;
    sd_valid = 1'b0;
    last_sd_cyc = 0;
    last_sd_epoch = 0;
    forever begin
      @(posedge adc_cs_n);
      if (rst_n) begin
        #1;
        if (sb_q.size() == 0) begin
          checkOutput("unexpected_frame", 1, 0);
        end else begin
          e = sb_q.pop_front();
          checkOutput("d_out_a", d_out_a, e.a);
          checkOutput("d_out_b", d_out_b, e.b);
          checkOutput("d_out_c", d_out_c, e.c);
          checkOutput("scan_done", scan_done, e.sd);
          checkOutput("din_addr", fr_addr, e.addr);
          checkOutput("din_other_bits", fr_din_other, 0);
          checkOutput("sck_rises", fr_sck, 16);
          checkOutput("cs_low_cycles", fr_cs, 32);
          if (e.sd) begin
            if (sd_valid && last_sd_epoch == rst_epoch)
              checkOutput("scan_period", cyc - last_sd_cyc, 102);
            sd_valid      = 1'b1;
            last_sd_cyc   = cyc;
            last_sd_epoch = rst_epoch;
          end
          @(posedge clk_3125KHz);
          #1;
          checkOutput("scan_done_width", scan_done, 0);
        end
      end
    end
  end

  // Watchdog
  initial begin
    #(6000 * 320);
    $display("[TB] FAIL watchdog: simulation did not complete, errors %0d", errors);
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed sequence: power-up, long run, mid-frame reset, junk leading bits
  initial begin
    rst_n = 1'b0;
    repeat (4) @(negedge clk_3125KHz);
    check_reset_state("por");

    resetShadow();
    applyStimulus(32);
    rst_n = 1'b1;
    wait_drain(32 * 34 + 200);

    rst_n = 1'b0;
    repeat (3) @(negedge clk_3125KHz);
    resetShadow();
    applyStimulus(2);
    rst_n = 1'b1;
    for (int i = 0; i < 400 && cs_falls < 3; i++) @(negedge clk_3125KHz);
    checkOutput("frame3_start_seen", cs_falls, 3);
    repeat (15) @(posedge clk_3125KHz);
    @(negedge clk_3125KHz);
    checkOutput("queue_empty_before_reset", sb_q.size(), 0);
    checkOutput("cs_low_before_reset", adc_cs_n, 0);
    checkOutput("a_before_reset", d_out_a, exp_ch5(0));
    rst_n = 1'b0;
    #1;
    check_reset_state("mid_frame");
    repeat (3) @(negedge clk_3125KHz);

    junk = 1'b1;
    resetShadow();
    applyStimulus(6);
    rst_n = 1'b1;
    wait_drain(6 * 34 + 200);

    checkOutput("never_555", saw_555, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
